// File: rtl/axis_frame_streamer.sv
// Host-side AXIS peer: streams one buffered frame out, then collects result words into a readable RAM.
// TX words leave one per cycle under M_AXIS_TREADY; RX is accepted only in RECV, so early results wait upstream.
module axis_frame_streamer #(
  parameter int DATA_WIDTH   = 32,
  parameter int TX_WORDS     = 467,
  parameter int TX_ADDR_BITS = 9,
  parameter int RX_WORDS     = 64,
  parameter int RX_ADDR_BITS = 6
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    LOAD_EN,
  input  logic [TX_ADDR_BITS-1:0] LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0]   LOAD_DATA,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR_TLAST,
  input  logic [RX_ADDR_BITS-1:0] RES_ADDR,
  output logic [DATA_WIDTH-1:0]   RES_DATA,
  output logic                    M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY,
  input  logic                    S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                    S_AXIS_TLAST,
  output logic                    S_AXIS_TREADY
);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_SEND = 3'b010;
  localparam logic [2:0] S_RECV = 3'b100;

  localparam logic [TX_ADDR_BITS-1:0] TX_LAST = TX_ADDR_BITS'(TX_WORDS - 1);
  localparam logic [RX_ADDR_BITS-1:0] RX_LAST = RX_ADDR_BITS'(RX_WORDS - 1);

  logic [DATA_WIDTH-1:0] tx_mem [0:(1 << TX_ADDR_BITS)-1];
  logic [DATA_WIDTH-1:0] rx_mem [0:(1 << RX_ADDR_BITS)-1];

  logic [2:0]              state;
  logic [TX_ADDR_BITS-1:0] tx_idx;
  logic [RX_ADDR_BITS-1:0] rx_idx;
  logic [TX_ADDR_BITS-1:0] tx_next;
  logic                    tx_fire;
  logic                    rx_fire;
  logic                    rx_at_last;
  logic                    rx_end;
  logic                    rx_bad;
  logic                    load_ok;

  assign tx_fire    = (state == S_SEND) && M_AXIS_TVALID && M_AXIS_TREADY;
  assign rx_fire    = (state == S_RECV) && S_AXIS_TVALID && S_AXIS_TREADY;
  assign rx_at_last = (rx_idx == RX_LAST);
  assign rx_end     = rx_at_last || S_AXIS_TLAST;
  // TLAST must coincide exactly with the final expected word; early or missing both flag.
  assign rx_bad     = (S_AXIS_TLAST != rx_at_last);
  assign tx_next    = tx_idx + 1'b1;
  assign load_ok    = LOAD_EN && (state == S_IDLE) && !ARESET;

  always_ff @(posedge ACLK) begin
    if (load_ok) begin
      tx_mem[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  always_ff @(posedge ACLK) begin
    if (rx_fire && !ARESET) begin
      rx_mem[rx_idx] <= S_AXIS_TDATA;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      RES_DATA <= '0;
    end else begin
      RES_DATA <= rx_mem[RES_ADDR];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= S_IDLE;
      tx_idx        <= '0;
      rx_idx        <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      ERR_TLAST     <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TDATA  <= '0;
      S_AXIS_TREADY <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          // A START landing on the DONE cycle is dropped.
          if (START && !DONE) begin
            state         <= S_SEND;
            tx_idx        <= '0;
            M_AXIS_TDATA  <= tx_mem[0];
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= (TX_LAST == '0);
            ERR_TLAST     <= 1'b0;
            BUSY          <= 1'b1;
          end
        end
        S_SEND: begin
          if (tx_fire) begin
            if (tx_idx == TX_LAST) begin
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TLAST  <= 1'b0;
              rx_idx        <= '0;
              S_AXIS_TREADY <= 1'b1;
              state         <= S_RECV;
            end else begin
              tx_idx       <= tx_next;
              M_AXIS_TDATA <= tx_mem[tx_next];
              M_AXIS_TLAST <= (tx_next == TX_LAST);
            end
          end
        end
        S_RECV: begin
          if (rx_fire) begin
            if (rx_bad) begin
              ERR_TLAST <= 1'b1;
            end
            if (rx_end) begin
              S_AXIS_TREADY <= 1'b0;
              DONE          <= 1'b1;
              BUSY          <= 1'b0;
              state         <= S_IDLE;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_streamer.sv
// Directed bench for axis_frame_streamer: frame transmit, stalls, result capture, TLAST errors, abort.
module tb_axis_frame_streamer;

  localparam int DW  = 32;
  localparam int TXW = 467;
  localparam int TXA = 9;
  localparam int RXW = 64;
  localparam int RXA = 6;

  logic           ACLK = 1'b0;
  logic           ARESET;
  logic           LOAD_EN;
  logic [TXA-1:0] LOAD_ADDR;
  logic [DW-1:0]  LOAD_DATA;
  logic           START;
  logic           BUSY;
  logic           DONE;
  logic           ERR_TLAST;
  logic [RXA-1:0] RES_ADDR;
  logic [DW-1:0]  RES_DATA;
  logic           M_AXIS_TVALID;
  logic [DW-1:0]  M_AXIS_TDATA;
  logic           M_AXIS_TLAST;
  logic           M_AXIS_TREADY;
  logic           S_AXIS_TVALID;
  logic [DW-1:0]  S_AXIS_TDATA;
  logic           S_AXIS_TLAST;
  logic           S_AXIS_TREADY;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  axis_frame_streamer #(
    .DATA_WIDTH(DW), .TX_WORDS(TXW), .TX_ADDR_BITS(TXA),
    .RX_WORDS(RXW), .RX_ADDR_BITS(RXA)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .START(START), .BUSY(BUSY), .DONE(DONE), .ERR_TLAST(ERR_TLAST),
    .RES_ADDR(RES_ADDR), .RES_DATA(RES_DATA),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Drives START then walks the frame; beat model is index i -> data i+1, TLAST on index TXW-1.
  task automatic send_frame(input bit stall, input int stop_beat, input int inj_beat);
    int idx;
    int cyc;
    logic rdy;
    logic [63:0] exp_beat;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_busy", 64'(BUSY), 64'(1'b1));
    check("start_err_clr", 64'(ERR_TLAST), 64'(1'b0));
    idx = 0;
    cyc = 0;
    while (idx < stop_beat && cyc < 5000) begin
      exp_beat = {30'd0, 1'b1, 1'(idx == TXW - 1), DW'(idx + 1)};
      check("tx_beat", {30'd0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, exp_beat);
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXIS_TREADY = rdy;
      if (idx == inj_beat) begin
        LOAD_EN   = 1'b1;
        LOAD_ADDR = TXA'(300);
        LOAD_DATA = 32'hDEAD_0000;
        START     = 1'b1;
      end
      tick();
      LOAD_EN = 1'b0;
      START   = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    M_AXIS_TREADY = 1'b0;
    check("tx_count", 64'(idx), 64'(stop_beat));
    if (stop_beat == TXW) begin
      check("tx_end_tvalid", 64'(M_AXIS_TVALID), 64'(1'b0));
      check("tx_end_tlast", 64'(M_AXIS_TLAST), 64'(1'b0));
      check("rx_entry_rdy", 64'(S_AXIS_TREADY), 64'(1'b1));
    end
  endtask

  // Sends n result words base+j; TLAST on index last_at (-1: never); gaps inserts idle cycles with TLAST high.
  task automatic recv_words(input int n, input int last_at, input logic [31:0] base,
                            input bit gaps, input logic exp_err);
    for (int j = 0; j < n; j++) begin
      if (gaps && (j % 2 == 1)) begin
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = 32'hFFFF_FFFF;
        S_AXIS_TLAST  = 1'b1;
        tick();
      end
      check("rx_rdy", 64'(S_AXIS_TREADY), 64'(1'b1));
      check("rx_no_done", 64'(DONE), 64'(1'b0));
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = base + DW'(j);
      S_AXIS_TLAST  = (j == last_at);
      tick();
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    check("rx_done", 64'(DONE), 64'(1'b1));
    check("rx_busy_clr", 64'(BUSY), 64'(1'b0));
    check("rx_rdy_clr", 64'(S_AXIS_TREADY), 64'(1'b0));
    check("rx_err", 64'(ERR_TLAST), 64'(exp_err));
  endtask

  task automatic read_res(input int addr, input logic [31:0] exp);
    RES_ADDR = RXA'(addr);
    tick();
    check("res_data", 64'(RES_DATA), 64'(exp));
  endtask

  initial begin
    ARESET        = 1'b1;
    LOAD_EN       = 1'b0;
    LOAD_ADDR     = '0;
    LOAD_DATA     = '0;
    START         = 1'b0;
    RES_ADDR      = '0;
    M_AXIS_TREADY = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(BUSY), 64'(1'b0));
    check("rst_done", 64'(DONE), 64'(1'b0));
    check("rst_err", 64'(ERR_TLAST), 64'(1'b0));
    check("rst_tvalid", 64'(M_AXIS_TVALID), 64'(1'b0));
    check("rst_tlast", 64'(M_AXIS_TLAST), 64'(1'b0));
    check("rst_tdata", 64'(M_AXIS_TDATA), 64'(0));
    check("rst_s_tready", 64'(S_AXIS_TREADY), 64'(1'b0));
    check("rst_res_data", 64'(RES_DATA), 64'(0));
    ARESET = 1'b0;

    for (int i = 0; i < TXW; i++) begin
      LOAD_EN   = 1'b1;
      LOAD_ADDR = TXA'(i);
      LOAD_DATA = DW'(i + 1);
      tick();
    end
    LOAD_EN = 1'b0;
    check("idle_busy", 64'(BUSY), 64'(1'b0));

    // Full-rate frame, then a clean 64-word result.
    send_frame(1'b0, TXW, -1);
    recv_words(RXW, RXW - 1, 32'hA0, 1'b0, 1'b0);
    tick();
    check("done_pulse_end", 64'(DONE), 64'(1'b0));
    read_res(5, 32'hA5);
    read_res(63, 32'hDF);
    read_res(0, 32'hA0);

    // Random stalls, then a short result terminated early by TLAST.
    send_frame(1'b1, TXW, -1);
    recv_words(10, 9, 32'h100, 1'b1, 1'b1);
    read_res(9, 32'h109);
    read_res(10, 32'hAA);
    read_res(63, 32'hDF);

    // Abort mid-frame with reset.
    send_frame(1'b0, 200, -1);
    check("abort_beat", 64'(M_AXIS_TDATA), 64'(201));
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    check("abort_tvalid", 64'(M_AXIS_TVALID), 64'(1'b0));
    check("abort_busy", 64'(BUSY), 64'(1'b0));
    check("abort_tlast", 64'(M_AXIS_TLAST), 64'(1'b0));
    tick();

    // Restart from word 0 with LOAD/START injected mid-SEND and again in RECV.
    send_frame(1'b0, TXW, 100);
    LOAD_EN   = 1'b1;
    LOAD_ADDR = '0;
    LOAD_DATA = 32'hBEEF;
    START     = 1'b1;
    tick();
    LOAD_EN = 1'b0;
    START   = 1'b0;
    check("recv_busy_hold", 64'(BUSY), 64'(1'b1));
    check("recv_rdy_hold", 64'(S_AXIS_TREADY), 64'(1'b1));
    check("recv_no_tvalid", 64'(M_AXIS_TVALID), 64'(1'b0));
    recv_words(RXW, RXW - 1, 32'h200, 1'b0, 1'b0);

    // START on the DONE cycle is dropped.
    START = 1'b1;
    tick();
    START = 1'b0;
    check("done_start_busy", 64'(BUSY), 64'(1'b0));
    check("done_start_tvalid", 64'(M_AXIS_TVALID), 64'(1'b0));
    check("done_start_done", 64'(DONE), 64'(1'b0));

    // TX buffer must still hold 1..467; result without TLAST flags an error.
    send_frame(1'b0, TXW, -1);
    recv_words(RXW, -1, 32'h300, 1'b0, 1'b1);
    read_res(63, 32'h33F);
    read_res(0, 32'h300);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
